// File: rtl/phat_xung_pkg.sv
// Shared mode codes, FSM state encoding and helpers for the phat_xung pulse-train generator.
package phat_xung_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_CONT  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Reserved mode 3 behaves like MODE_OFF.
    function automatic logic mode_active(input logic [1:0] mode);
        return (mode == MODE_CONT) || (mode == MODE_BURST);
    endfunction

endpackage

// File: rtl/phat_xung_if.sv
// Configuration/status bundle of phat_xung: settings and LOAD in, pulse train and strobes out.
interface phat_xung_if
    import phat_xung_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 9
) ();
    logic [1:0]    mode;
    logic [W-1:0]  period;
    logic [W-1:0]  high;
    logic [CW-1:0] nburst;
    logic          load;
    logic          load_ack;
    logic          pulseout;
    logic          busy;
    logic          done;

    modport master (
        output mode, period, high, nburst, load,
        input  load_ack, pulseout, busy, done
    );

    modport slave (
        input  mode, period, high, nburst, load,
        output load_ack, pulseout, busy, done
    );
endinterface

// File: rtl/phat_xung_shadow.sv
// Double-buffered settings: LOAD fills the pending set, a transfer window moves it to the active set.
module phat_xung_shadow
    import phat_xung_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [W-1:0]  period_i,
    input  logic [W-1:0]  high_i,
    input  logic [CW-1:0] nburst_i,
    input  logic          xfer_ok_i,
    output logic          pend_v_o,
    output logic [W-1:0]  pend_per_o,
    output logic [W-1:0]  pend_high_o,
    output logic [W-1:0]  act_per_o,
    output logic [W-1:0]  act_high_o,
    output logic [CW-1:0] act_nb_o,
    output logic          xfer_o,
    output logic          xfer_q_o,
    output logic          load_ack_o
);
    logic          pend_v_q, pend_v_d;
    logic [W-1:0]  pend_per_q, pend_per_d, pend_high_q, pend_high_d;
    logic [CW-1:0] pend_nb_q, pend_nb_d;
    logic [W-1:0]  act_per_q, act_per_d, act_high_q, act_high_d;
    logic [CW-1:0] act_nb_q, act_nb_d;
    logic          xfer_s, xfer_q, ack_q;

    // Next-state of pending/active banks; a LOAD in the transfer cycle refills pending.
    always_comb begin
        xfer_s      = pend_v_q && xfer_ok_i;
        pend_v_d    = pend_v_q;
        pend_per_d  = pend_per_q;
        pend_high_d = pend_high_q;
        pend_nb_d   = pend_nb_q;
        act_per_d   = act_per_q;
        act_high_d  = act_high_q;
        act_nb_d    = act_nb_q;
        if (xfer_s) begin
            act_per_d  = pend_per_q;
            act_high_d = pend_high_q;
            act_nb_d   = pend_nb_q;
            pend_v_d   = 1'b0;
        end else begin
            pend_v_d   = pend_v_q;
        end
        if (load_i) begin
            pend_per_d  = period_i;
            pend_high_d = high_i;
            pend_nb_d   = nburst_i;
            pend_v_d    = 1'b1;
        end else begin
            pend_nb_d   = pend_nb_q;
        end
    end

    // Register banks; LOAD_ACK follows the transfer by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q    <= 1'b0;
            pend_per_q  <= {W{1'b0}};
            pend_high_q <= {W{1'b0}};
            pend_nb_q   <= {CW{1'b0}};
            act_per_q   <= {W{1'b0}};
            act_high_q  <= {W{1'b0}};
            act_nb_q    <= {CW{1'b0}};
            xfer_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_per_q  <= pend_per_d;
            pend_high_q <= pend_high_d;
            pend_nb_q   <= pend_nb_d;
            act_per_q   <= act_per_d;
            act_high_q  <= act_high_d;
            act_nb_q    <= act_nb_d;
            xfer_q      <= xfer_s;
            ack_q       <= xfer_q;
        end
    end

    assign pend_v_o    = pend_v_q;
    assign pend_per_o  = pend_per_q;
    assign pend_high_o = pend_high_q;
    assign act_per_o   = act_per_q;
    assign act_high_o  = act_high_q;
    assign act_nb_o    = act_nb_q;
    assign xfer_o      = xfer_s;
    assign xfer_q_o    = xfer_q;
    assign load_ack_o  = ack_q;
endmodule

// File: rtl/phat_xung.sv
// Programmable pulse-train generator (continuous or burst) with boundary-aligned setting updates.
// Optional pulse counter output cnt is built when PULSE_CNT_EN is defined.
module phat_xung
    import phat_xung_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    phat_xung_if.slave    bus
`ifdef PULSE_CNT_EN
    ,
    output logic [CW-1:0] cnt
`endif
);
    state_e        state_q, state_d;
    logic [W-1:0]  tcnt_q, tcnt_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          burst_q, burst_d, fresh_q, fresh_d;
    logic          pulse_q, pulse_d, busy_q, done_q, done_d;
    logic          pend_v_s, xfer_s, xfer_q_s, ack_s, boundary_s, xfer_ok_s, burst_end_s;
    logic [W-1:0]  pend_per_s, pend_high_s, act_per_s, act_high_s, eff_high_s;
    logic [CW-1:0] act_nb_s;

    assign boundary_s = (state_q == ST_RUN) && (tcnt_q == act_per_s - W'(1));
    assign xfer_ok_s  = (state_q == ST_IDLE) || boundary_s;
    assign eff_high_s = xfer_s ? pend_high_s : act_high_s;

    phat_xung_shadow #(.W(W), .CW(CW)) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .load_i     (bus.load),
        .period_i   (bus.period),
        .high_i     (bus.high),
        .nburst_i   (bus.nburst),
        .xfer_ok_i  (xfer_ok_s),
        .pend_v_o   (pend_v_s),
        .pend_per_o (pend_per_s),
        .pend_high_o(pend_high_s),
        .act_per_o  (act_per_s),
        .act_high_o (act_high_s),
        .act_nb_o   (act_nb_s),
        .xfer_o     (xfer_s),
        .xfer_q_o   (xfer_q_s),
        .load_ack_o (ack_s)
    );

    // FSM next state, period/burst counters and pulse level for the coming cycle.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        burst_d     = burst_q;
        fresh_d     = fresh_q;
        done_d      = 1'b0;
        burst_end_s = burst_q && ((CW+1)'(bcnt_q) + (CW+1)'(1) >= (CW+1)'(act_nb_s));
        case (state_q)
            ST_IDLE: begin
                // Start only once no setting update is still in flight.
                if (mode_active(bus.mode) && (act_per_s >= W'(2)) && !pend_v_s && !xfer_q_s &&
                    ((bus.mode != MODE_BURST) || ((act_nb_s != {CW{1'b0}}) && fresh_q))) begin
                    state_d = ST_RUN;
                    tcnt_d  = {W{1'b0}};
                    bcnt_d  = {CW{1'b0}};
                    burst_d = (bus.mode == MODE_BURST);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (boundary_s) begin
                    tcnt_d = {W{1'b0}};
                    if (burst_end_s) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        fresh_d = 1'b0;
                    end else if (!mode_active(bus.mode) || (xfer_s && (pend_per_s < W'(2)))) begin
                        state_d = ST_IDLE;
                    end else begin
                        burst_d = (bus.mode == MODE_BURST);
                        bcnt_d  = (burst_q && (bus.mode == MODE_BURST)) ? bcnt_q + CW'(1) : {CW{1'b0}};
                    end
                end else begin
                    tcnt_d = tcnt_q + W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (xfer_s) begin
            fresh_d = 1'b1;
        end else begin
            fresh_d = fresh_d;
        end
        pulse_d = (state_d == ST_RUN) && (tcnt_d < eff_high_s);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tcnt_q  <= {W{1'b0}};
            bcnt_q  <= {CW{1'b0}};
            burst_q <= 1'b0;
            fresh_q <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            burst_q <= burst_d;
            fresh_q <= fresh_d;
            pulse_q <= pulse_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= done_d;
        end
    end

    assign bus.pulseout = pulse_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.load_ack = ack_s;

`ifdef PULSE_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inc_s;

    // Period starts since LOAD_ACK; cleared as LOAD_ACK rises, saturating.
    always_comb begin
        inc_s = (state_q == ST_RUN) && (tcnt_q == {W{1'b0}});
        cnt_d = cnt_q;
        if (xfer_q_s) begin
            cnt_d = inc_s ? CW'(1) : {CW{1'b0}};
        end else if (inc_s && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pulse counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif
endmodule

// File: tb/tb_phat_xung.sv
// Directed self-checking bench for phat_xung; cnt checks are compiled with PULSE_CNT_EN.
module tb_phat_xung;
    import phat_xung_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
`ifdef PULSE_CNT_EN
    logic [8:0] cnt;
`endif

    phat_xung_if #(.W(16), .CW(9)) bus ();

    phat_xung #(.W(16), .CW(9)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef PULSE_CNT_EN
        ,
        .cnt(cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // LOAD issued with MODE off, mode applied right after the capture edge.
    task automatic start(input logic [1:0] m, input logic [15:0] p, input logic [15:0] h,
                         input logic [8:0] n);
        bus.period = p;
        bus.high   = h;
        bus.nburst = n;
        bus.load   = 1'b1;
        step();
        bus.load = 1'b0;
        bus.mode = m;
        check("ack_k", bus.load_ack, 0);
        step();
        check("ack_k1", bus.load_ack, 0);
        step();
        check("ack_k2", bus.load_ack, 1);
        step();
        check("ack_k3", bus.load_ack, 0);
    endtask

    task automatic go_idle();
        int n;
        n = 0;
        bus.mode = MODE_OFF;
        while (bus.busy && n < 200) begin
            step();
            n++;
        end
        check("idle_reached", (n < 200), 1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.mode   = MODE_OFF;
        bus.period = 16'd0;
        bus.high   = 16'd0;
        bus.nburst = 9'd0;
        bus.load   = 1'b0;
        step(); step(); step();
        check("rst_pulse", bus.pulseout, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ack", bus.load_ack, 0);
        rst = 1'b0;
        step();

        // Continuous 10/3 train.
        start(MODE_CONT, 16'd10, 16'd3, 9'd0);
        for (int c = 0; c < 20; c++) begin
            check("t1_pulse", bus.pulseout, ((c % 10) < 3) ? 1 : 0);
            check("t1_busy", bus.busy, 1);
            step();
        end
        // Mid-period reload to PERIOD=20 HIGH=5.
        step(); step();
        bus.period = 16'd20;
        bus.high   = 16'd5;
        bus.load   = 1'b1;
        step();
        bus.load = 1'b0;
        for (int c = 23; c < 30; c++) begin
            check("t3_old_tail", bus.pulseout, 0);
            check("t3_no_ack", bus.load_ack, 0);
            step();
        end
        for (int j = 0; j < 40; j++) begin
            check("t3_pulse", bus.pulseout, ((j % 20) < 5) ? 1 : 0);
            check("t3_ack", bus.load_ack, (j == 1) ? 1 : 0);
            step();
        end

        // HIGH=0 then HIGH=PERIOD, reload captured on a boundary edge.
        go_idle();
        start(MODE_CONT, 16'd6, 16'd0, 9'd0);
        for (int c = 0; c < 12; c++) begin
            check("t4_low", bus.pulseout, 0);
            check("t4_busy", bus.busy, 1);
            if (c == 11) begin
                bus.high = 16'd6;
                bus.load = 1'b1;
            end
            step();
            bus.load = 1'b0;
        end
        for (int c = 12; c < 30; c++) begin
            check("t4_high", bus.pulseout, (c >= 18) ? 1 : 0);
            check("t4_busy2", bus.busy, 1);
            step();
        end

        // Burst of 5 pulses, 8/4; no restart without a new LOAD.
        go_idle();
        start(MODE_BURST, 16'd8, 16'd4, 9'd5);
        for (int c = 0; c < 70; c++) begin
            check("t2_pulse", bus.pulseout, ((c < 40) && ((c % 8) < 4)) ? 1 : 0);
            check("t2_done", bus.done, (c == 40) ? 1 : 0);
            check("t2_busy", bus.busy, (c < 40) ? 1 : 0);
            step();
        end

        // MODE 1->0 at tcnt=2: period completes.
        go_idle();
        start(MODE_CONT, 16'd10, 16'd5, 9'd0);
        for (int c = 0; c < 13; c++) begin
            check("t5_pulse", bus.pulseout, (c < 5) ? 1 : 0);
            check("t5_busy", bus.busy, (c < 10) ? 1 : 0);
            if (c == 2) bus.mode = MODE_OFF;
            step();
        end
        // Reset in the middle of a pulse.
        start(MODE_CONT, 16'd10, 16'd5, 9'd0);
        step(); step();
        check("t5_pre_rst", bus.pulseout, 1);
        rst = 1'b1;
        step();
        check("t5_rst_pulse", bus.pulseout, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_done", bus.done, 0);
        check("t5_rst_ack", bus.load_ack, 0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t5_post_rst", bus.busy, 0);
        end

        // Shortest legal period.
        go_idle();
        start(MODE_CONT, 16'd2, 16'd1, 9'd0);
        for (int c = 0; c < 6; c++) begin
            check("p2_pulse", bus.pulseout, ((c % 2) == 0) ? 1 : 0);
            step();
        end
        go_idle();

`ifdef PULSE_CNT_EN
        start(MODE_BURST, 16'd4, 16'd1, 9'd7);
        for (int c = 0; c < 32; c++) begin
            check("t6_cnt", cnt, (((c + 3) / 4) > 7) ? 7 : (c + 3) / 4);
            step();
        end
        check("t6_cnt7", cnt, 7);
`endif

        // PERIOD=1 never starts.
        start(MODE_CONT, 16'd1, 16'd0, 9'd0);
`ifdef PULSE_CNT_EN
        check("t6_cnt_clr", cnt, 0);
`endif
        for (int c = 0; c < 10; c++) begin
            check("t6_per1_busy", bus.busy, 0);
            check("t6_per1_pulse", bus.pulseout, 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
